disp_scan_ctrl: RTL and testbench

// - Sequences the stopwatch's 4-digit multiplexed seven-segment display.
// - Scans one digit per refresh tick.
// - Normally shows the stopwatch BCD digits. On request, shows a timed status message built from

---
 rtl/disp_pkg.sv | 36 +++
 rtl/seg_glyph_dec.sv | 42 ++++
 rtl/disp_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg
// Shared constants for the stopwatch display scanner:
//   - 2-bit letter codes used in status messages (E, L, A, blank)
//   - seven-segment glyphs, bit 6 = segment a down to bit 0 = segment g
//   - display mode encoding and the number of multiplexed digits
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [1:0] LTR_E     = 2'd0;
  localparam logic [1:0] LTR_L     = 2'd1;
  localparam logic [1:0] LTR_A     = 2'd2;
  localparam logic [1:0] LTR_BLANK = 2'd3;

  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_L     = 7'b0001110;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  typedef enum logic {
    MODE_NUM = 1'b0,
    MODE_MSG = 1'b1
  } mode_t;

endpackage

// File: rtl/seg_glyph_dec.sv
// seg_glyph_dec
// Combinational glyph lookup for one seven-segment digit.
// Ports:
//   is_letter  in   1  1 = val[1:0] is a letter code, 0 = val is a BCD digit
//   val        in   4  BCD digit (0..9, 10..15 dark) or letter code in bits 1:0
//   seg        out  7  active-high segments, seg[6]=a .. seg[0]=g
module seg_glyph_dec
  import disp_pkg::*;
(
  input  logic       is_letter,
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Letter codes ignore val[3:2]; non-decimal BCD values stay dark.
  always_comb begin
    seg = SEG_BLANK;
    if (is_letter) begin
      case (val[1:0])
        LTR_E:   seg = SEG_E;
        LTR_L:   seg = SEG_L;
        LTR_A:   seg = SEG_A;
        default: seg = SEG_BLANK;
      endcase
    end else begin
      case (val)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Drives the stopwatch's 4-digit multiplexed seven-segment display. One digit
// is lit per refresh tick. Normally the stopwatch BCD digits are shown; a
// msg_req pulse switches to a timed letter message that expires on its own.
// Ports:
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   disp_en     in   1   0 = all anodes off (scanning keeps running)
//   bcd_digits  in   16  digit3..digit0 BCD from the stopwatch core
//   dp_mask     in   4   decimal point per digit, numeric mode only
//   msg_req     in   1   single-cycle request: latch msg_code, show message
//   msg_code    in   8   digit3..digit0 letter codes, 2 bits each
//   msg_busy    out  1   high while the message is on screen
//   an          out  4   anodes, active-low
//   seg         out  7   segments, active-high, seg[6]=a .. seg[0]=g
//   dp          out  1   decimal point, active-high
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 100000,
  parameter int MSG_HOLD_TICKS = 2000,
  parameter int LZ_SUPPRESS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_en,
  input  logic [15:0] bcd_digits,
  input  logic [3:0]  dp_mask,
  input  logic        msg_req,
  input  logic [7:0]  msg_code,
  output logic        msg_busy,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int HOLD_W = (MSG_HOLD_TICKS > 1) ? $clog2(MSG_HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MSG_HOLD_TICKS - 1);

  logic [CNT_W-1:0]      refresh_cnt;
  logic                  tick;
  logic [1:0]            idx;
  mode_t                 mode;
  logic [HOLD_W-1:0]     hold;
  logic [7:0]            code_q;
  logic [NUM_DIGITS-1:0] scan_an;
  logic [NUM_DIGITS-1:0] an_next;
  logic [3:0]            cur_val;
  logic [3:0]            lz_blank;
  logic                  dec_letter;
  logic [3:0]            dec_val;
  logic [6:0]            dec_seg;

  assign tick = (refresh_cnt == CNT_LAST);

  // Free-running refresh divider; one scan tick every REFRESH_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // idx names the digit that the next tick lights, so the first tick after
  // reset lights digit 0 and idx then moves on to the following digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Mode FSM with hold counter. A request always wins, including on the
  // tick where the current message would expire, so it reloads the hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= MODE_NUM;
      hold     <= '0;
      code_q   <= 8'hFF;
      msg_busy <= 1'b0;
    end else if (msg_req) begin
      mode     <= MODE_MSG;
      hold     <= HOLD_LOAD;
      code_q   <= msg_code;
      msg_busy <= 1'b1;
    end else if (mode == MODE_MSG && tick) begin
      if (hold == '0) begin
        mode     <= MODE_NUM;
        msg_busy <= 1'b0;
      end else begin
        hold <= hold - 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 always shows, so a reading of all zeros still displays "0".
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (bcd_digits[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (bcd_digits[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (bcd_digits[7:4] == 4'd0);
  end

  assign cur_val = bcd_digits[{idx, 2'b00} +: 4];

  // Pick what the decoder sees for the digit about to be lit. The mode
  // register is used as-is, so a mode change shows up at the next tick.
  always_comb begin
    dec_letter = 1'b0;
    dec_val    = cur_val;
    if (mode == MODE_MSG) begin
      dec_letter = 1'b1;
      dec_val    = {2'b00, code_q[{idx, 1'b0} +: 2]};
    end else if (LZ_SUPPRESS != 0 && lz_blank[idx]) begin
      dec_letter = 1'b1;
      dec_val    = {2'b00, LTR_BLANK};
    end
  end

  seg_glyph_dec u_glyph (
    .is_letter (dec_letter),
    .val       (dec_val),
    .seg       (dec_seg)
  );

  assign an_next = ~(4'b0001 << idx);

  // seg/dp and the scan anode pattern change only on ticks. The anode pins
  // are re-registered every cycle so disp_en blanks the display promptly
  // without disturbing the scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_an <= 4'b1111;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
      dp      <= 1'b0;
    end else if (tick) begin
      scan_an <= an_next;
      an      <= disp_en ? an_next : 4'b1111;
      seg     <= dec_seg;
      dp      <= (mode == MODE_NUM) ? dp_mask[idx] : 1'b0;
    end else begin
      an <= disp_en ? scan_an : 4'b1111;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
// Scoreboard bench for disp_scan_ctrl. The driver applies one input vector
// per clock at the falling edge, advances a behavioural model of the display
// and queues the outputs expected after the next rising edge. A separate
// monitor pops and compares shortly after every rising edge.
module tb_disp_scan_ctrl;

  localparam int DIV  = 4;
  localparam int HOLD = 8;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        disp_en;
  logic [15:0] bcd_digits;
  logic [3:0]  dp_mask;
  logic        msg_req;
  logic [7:0]  msg_code;
  logic        msg_busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   rel_req = 1'b0;

  // Model state: cycles into the current refresh period, ticks seen since
  // reset, remaining message ticks and the message text being displayed.
  int         m_cnt;
  int         m_tick;
  int         m_msg_left;
  logic [7:0] m_code;
  logic [3:0] m_scan;
  logic [6:0] m_seg;
  logic       m_dp;

  disp_scan_ctrl #(
    .REFRESH_DIV    (DIV),
    .MSG_HOLD_TICKS (HOLD),
    .LZ_SUPPRESS    (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_en    (disp_en),
    .bcd_digits (bcd_digits),
    .dp_mask    (dp_mask),
    .msg_req    (msg_req),
    .msg_code   (msg_code),
    .msg_busy   (msg_busy),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph tables written straight from the display's segment definitions.
  function automatic logic [6:0] digit_glyph(input int v);
    case (v)
      0:       return 7'b1111110;
      1:       return 7'b0110000;
      2:       return 7'b1101101;
      3:       return 7'b1111001;
      4:       return 7'b0110011;
      5:       return 7'b1011011;
      6:       return 7'b1011111;
      7:       return 7'b1110000;
      8:       return 7'b1111111;
      9:       return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] letter_glyph(input int c);
    case (c)
      0:       return 7'b1001111;
      1:       return 7'b0001110;
      2:       return 7'b1110111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic modelReset();
    m_cnt      = 0;
    m_tick     = 0;
    m_msg_left = 0;
    m_code     = 8'hFF;
    m_scan     = 4'b1111;
    m_seg      = 7'd0;
    m_dp       = 1'b0;
  endtask

  // One clock of stimulus plus the model's view of the outputs after the
  // following rising edge.
  task automatic applyStimulus(input logic en, input logic [15:0] bcd,
                               input logic [3:0] dpm, input logic req,
                               input logic [7:0] code);
    int  lit;
    int  upper;
    bit  tick;
    @(negedge clk);
    if (rel_req) begin
      rst_n   = 1'b1;
      rel_req = 1'b0;
    end
    disp_en    = en;
    bcd_digits = bcd;
    dp_mask    = dpm;
    msg_req    = req;
    msg_code   = code;
    if (!rst_n) begin
      modelReset();
      sb.push_back('{an: 4'b1111, seg: 7'd0, dp: 1'b0, busy: 1'b0});
      return;
    end
    tick = (m_cnt == DIV - 1);
    if (tick) begin
      lit         = m_tick % 4;
      m_scan      = 4'b1111;
      m_scan[lit] = 1'b0;
      if (m_msg_left > 0) begin
        m_seg = letter_glyph((int'(m_code) >> (2 * lit)) & 3);
        m_dp  = 1'b0;
      end else begin
        upper = int'(bcd) >> (4 * lit);
        if (lit != 0 && upper == 0) m_seg = 7'd0;
        else m_seg = digit_glyph(upper & 15);
        m_dp = dpm[lit];
      end
      m_tick++;
    end
    if (req) begin
      m_msg_left = HOLD;
      m_code     = code;
    end else if (tick && m_msg_left > 0) begin
      m_msg_left--;
    end
    m_cnt = (m_cnt + 1) % DIV;
    sb.push_back('{an: (en ? m_scan : 4'b1111), seg: m_seg, dp: m_dp,
                   busy: (m_msg_left > 0)});
  endtask

  task automatic checkOutput(input exp_t e);
    n_vec++;
    if (an !== e.an || seg !== e.seg || dp !== e.dp || msg_busy !== e.busy) begin
      n_miss++;
      $display("[TB] FAIL outputs t=%0t: got an=%b seg=%b dp=%b busy=%b, want an=%b seg=%b dp=%b busy=%b",
               $time, an, seg, dp, msg_busy, e.an, e.seg, e.dp, e.busy);
    end
  endtask

  // Asynchronous reset dropped between clock edges: the outputs must go to
  // their reset values before any further clock edge.
  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (an !== 4'b1111 || msg_busy !== 1'b0 || seg !== 7'd0 || dp !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL async_reset: got an=%b busy=%b seg=%b dp=%b, want an=1111 busy=0 seg=0 dp=0",
               an, msg_busy, seg, dp);
    end
    modelReset();
  endtask

  task automatic idle(input int n, input logic [15:0] bcd, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(en, bcd, 4'b0000, 1'b0, 8'hFF);
  endtask

  // Monitor: compares whatever the driver queued for this edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          start_tick;
    logic [15:0] rbcd;
    rst_n      = 1'b0;
    disp_en    = 1'b1;
    bcd_digits = 16'h0000;
    dp_mask    = 4'b0000;
    msg_req    = 1'b0;
    msg_code   = 8'hFF;
    modelReset();

    idle(2, 16'h1234, 1'b1);
    rel_req = 1'b1;

    // Plain numeric scan, then leading-zero blanking.
    idle(24, 16'h1234, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'h0050, 4'b0101, 1'b0, 8'hFF);
    idle(16, 16'h0000, 1'b1);

    // Message: blank, E, L, A, retriggered with all blanks on its 5th tick.
    applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b1, 8'b11_00_01_10);
    start_tick = m_tick;
    for (int k = 0; k < 200 && !(m_cnt == DIV - 1 && m_tick - start_tick == 4); k++)
      idle(1, 16'h0987, 1'b1);
    applyStimulus(1'b1, 16'h0987, 4'b0000, 1'b1, 8'hFF);
    idle(40, 16'h0987, 1'b1);

    // Request landing exactly on the expiry tick keeps the message up.
    applyStimulus(1'b1, 16'h0987, 4'b0000, 1'b1, 8'b00_01_10_11);
    for (int k = 0; k < 200 && !(m_cnt == DIV - 1 && m_msg_left == 1); k++)
      idle(1, 16'h0987, 1'b1);
    applyStimulus(1'b1, 16'h0987, 4'b0000, 1'b1, 8'b10_10_01_00);
    idle(44, 16'h0987, 1'b1);

    // Display disabled for 10 clocks while scanning continues.
    idle(10, 16'h5678, 1'b0);
    idle(12, 16'h5678, 1'b1);

    // Reset in the middle of a message.
    applyStimulus(1'b1, 16'h4321, 4'b0000, 1'b1, 8'b00_00_00_00);
    idle(9, 16'h4321, 1'b1);
    asyncReset();
    idle(3, 16'h4321, 1'b1);
    rel_req = 1'b1;
    idle(20, 16'h4321, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 700; i++) begin
      for (int d = 0; d < 4; d++)
        rbcd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 7) != 0), rbcd, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 39) == 0), 8'($urandom_range(0, 255)));
    end
    idle(8, 16'h0000, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
